// File: rtl/arm_mem_pkg.sv
// Shared types for the instruction/data RAM port arbiter.
`timescale 1ns/1ps
package arm_mem_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } mem_arb_state_t;

   typedef enum logic [0:0] {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } mem_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-port I/D RAM between instruction fetch and load/store.
// LS wins arbitration until a streak limit is hit while fetch is waiting.
`timescale 1ns/1ps
module mem_port_arbiter
   import arm_mem_pkg::*;
#(
   parameter int unsigned ADDR_W        = 11,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned RAM_LAT       = 2,
   parameter int unsigned MAX_LS_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_w_en,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   localparam int unsigned LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
   localparam int unsigned STK_W = $clog2(MAX_LS_STREAK + 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RAM_LAT - 1);
   localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_LS_STREAK);

   mem_arb_state_t   state_q, state_d;
   mem_owner_t       owner_q;
   logic [LAT_W-1:0] lat_cnt_q;
   logic [STK_W-1:0] streak_q;
   logic             drop_q;

   logic eff_if, grant_if, grant_ls, grant_rd, rd_last, if_cap, ls_cap;

   // Arbitration, only evaluated in IDLE; a flushing fetch never wins.
   assign eff_if   = if_req & ~if_flush;
   assign grant_if = (state_q == IDLE) & eff_if & (~ls_req | (streak_q == STK_MAX));
   assign grant_ls = (state_q == IDLE) & ls_req & ~grant_if;
   assign grant_rd = grant_if | (grant_ls & ~ls_we);
   assign rd_last  = (state_q == RD_WAIT) & (lat_cnt_q == LAT_LAST);
   assign if_cap   = rd_last & (owner_q == OWN_IF) & ~drop_q & ~if_flush;
   assign ls_cap   = rd_last & (owner_q == OWN_LS);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: stores stay in IDLE, reads wait out the RAM latency.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_rd) state_d = RD_WAIT;
         RD_WAIT: if (rd_last)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant-cycle outputs; the RAM port is quiet outside grant cycles.
   always_comb begin
      if_gnt    = 1'b0;
      ls_gnt    = 1'b0;
      ram_addr  = '0;
      ram_w_en  = 1'b0;
      ram_wdata = '0;
      busy      = (state_q != IDLE);
      if (grant_if) begin
         if_gnt   = 1'b1;
         ram_addr = if_addr;
      end else if (grant_ls) begin
         ls_gnt   = 1'b1;
         ram_addr = ls_addr;
         ram_w_en = ls_we;
         if (ls_we) ram_wdata = ls_wdata;
      end
   end

   // Latency counter, read owner and fetch-drop flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_cnt_q <= '0;
         owner_q   <= OWN_IF;
         drop_q    <= 1'b0;
      end else begin
         if (grant_rd) begin
            lat_cnt_q <= '0;
            owner_q   <= grant_if ? OWN_IF : OWN_LS;
         end else if (state_q == RD_WAIT) begin
            lat_cnt_q <= rd_last ? '0 : lat_cnt_q + LAT_W'(1);
         end
         if (grant_rd || rd_last) begin
            drop_q <= 1'b0;
         end else if ((state_q == RD_WAIT) && (owner_q == OWN_IF) && if_flush) begin
            drop_q <= 1'b1;
         end
      end
   end

   // LS streak: counts LS wins while fetch waits, saturating at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak_q <= '0;
      end else if (!if_req || grant_if) begin
         streak_q <= '0;
      end else if (grant_ls && (streak_q != STK_MAX)) begin
         streak_q <= streak_q + STK_W'(1);
      end
   end

   // Read return registers; each requester's data is held until its next pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rvalid <= 1'b0;
         ls_rvalid <= 1'b0;
         if_rdata  <= '0;
         ls_rdata  <= '0;
      end else begin
         if_rvalid <= if_cap;
         ls_rvalid <= ls_cap;
         if (if_cap) if_rdata <= ram_rdata;
         if (ls_cap) ls_rdata <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a preloaded RAM model and read scoreboards.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W  = 11;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned RAM_LAT = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              if_req = 1'b0, if_flush = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              ls_req = 1'b0, ls_we = 1'b0;
   logic [ADDR_W-1:0] ls_addr = '0;
   logic [DATA_W-1:0] ls_wdata = '0;
   logic              if_gnt, if_rvalid, ls_gnt, ls_rvalid, ram_w_en, busy;
   logic [DATA_W-1:0] if_rdata, ls_rdata, ram_wdata, ram_rdata;
   logic [ADDR_W-1:0] ram_addr;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] ifq[$];
   logic [DATA_W-1:0] lsq[$];
   logic [DATA_W-1:0] exp_if_rdata, exp_ls_rdata, popped;

   logic [DATA_W-1:0] mem [1 << ADDR_W];
   logic [ADDR_W-1:0] pipe [RAM_LAT];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .MAX_LS_STREAK(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
      .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .busy(busy)
   );

   // RAM model: data for an address cycle appears RAM_LAT cycles later.
   always @(posedge clk) begin
      if (ram_w_en) mem[ram_addr] <= ram_wdata;
      pipe[0] <= ram_addr;
      for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign ram_rdata = mem[pipe[RAM_LAT-1]];

   function automatic logic [DATA_W-1:0] init_word(input int unsigned a);
      return 32'hA000_0000 | DATA_W'(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every rvalid pulse must match the oldest expected word.
   task automatic scb();
      if (rst_n && if_rvalid) begin
         checks++;
         assert (ifq.size() != 0) else begin
            errors++;
            $error("FAIL if_rvalid_unexpected observed 1 expected 0");
         end
         if (ifq.size() != 0) begin
            popped = ifq.pop_front();
            chk("if_scb_data", if_rdata, popped);
         end
      end
      if (rst_n && ls_rvalid) begin
         checks++;
         assert (lsq.size() != 0) else begin
            errors++;
            $error("FAIL ls_rvalid_unexpected observed 1 expected 0");
         end
         if (lsq.size() != 0) begin
            popped = lsq.pop_front();
            chk("ls_scb_data", ls_rdata, popped);
         end
      end
   endtask

   task automatic nxt();
      scb();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         nxt();
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
      chk({tag, "_ls_gnt"}, 32'(ls_gnt), 32'd0);
      chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
      chk({tag, "_ls_rvalid"}, 32'(ls_rvalid), 32'd0);
      chk({tag, "_if_rdata"}, if_rdata, 32'd0);
      chk({tag, "_ls_rdata"}, ls_rdata, 32'd0);
      chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      chk({tag, "_ram_w_en"}, 32'(ram_w_en), 32'd0);
      chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n_gnt;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = init_word(i);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);

      // 1: lone fetch
      if_req = 1'b1; if_addr = 11'h010;
      @(negedge clk);
      chk("t1_if_gnt", 32'(if_gnt), 32'd1);
      chk("t1_ram_addr", 32'(ram_addr), 32'h010);
      chk("t1_busy_t0", 32'(busy), 32'd0);
      ifq.push_back(init_word(32'h010)); exp_if_rdata = init_word(32'h010);
      nxt();
      if_req = 1'b0;
      @(negedge clk);
      chk("t1_busy_t1", 32'(busy), 32'd1);
      chk("t1_ram_addr_t1", 32'(ram_addr), 32'd0);
      nxt();
      @(negedge clk);
      chk("t1_rvalid_t2", 32'(if_rvalid), 32'd0);
      nxt();
      @(negedge clk);
      chk("t1_rvalid_t3", 32'(if_rvalid), 32'd1);
      chk("t1_rdata_t3", if_rdata, exp_if_rdata);
      chk("t1_busy_t3", 32'(busy), 32'd0);
      nxt();

      // 2: LS load beats a simultaneous fetch
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 11'h020;
      if_req = 1'b1; if_addr = 11'h011;
      @(negedge clk);
      chk("t2_ls_gnt", 32'(ls_gnt), 32'd1);
      chk("t2_if_gnt_t0", 32'(if_gnt), 32'd0);
      chk("t2_ram_addr", 32'(ram_addr), 32'h020);
      lsq.push_back(init_word(32'h020)); exp_ls_rdata = init_word(32'h020);
      nxt();
      ls_req = 1'b0;
      @(negedge clk); chk("t2_if_gnt_t1", 32'(if_gnt), 32'd0); nxt();
      @(negedge clk); chk("t2_if_gnt_t2", 32'(if_gnt), 32'd0); nxt();
      @(negedge clk);
      chk("t2_ls_rvalid_t3", 32'(ls_rvalid), 32'd1);
      chk("t2_if_gnt_t3", 32'(if_gnt), 32'd1);
      chk("t2_ram_addr_t3", 32'(ram_addr), 32'h011);
      chk("t2_if_rdata_held", if_rdata, exp_if_rdata);
      ifq.push_back(init_word(32'h011)); exp_if_rdata = init_word(32'h011);
      nxt();
      if_req = 1'b0;
      idle(2);
      @(negedge clk);
      chk("t2_if_rvalid_t6", 32'(if_rvalid), 32'd1);
      chk("t2_ls_rdata_held", ls_rdata, exp_ls_rdata);
      nxt();

      // 3: store then load-back
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 11'h030; ls_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t3_st_gnt", 32'(ls_gnt), 32'd1);
      chk("t3_st_w_en", 32'(ram_w_en), 32'd1);
      chk("t3_st_wdata", ram_wdata, 32'hDEAD_BEEF);
      chk("t3_st_busy", 32'(busy), 32'd0);
      nxt();
      ls_we = 1'b0; ls_wdata = '0;
      @(negedge clk);
      chk("t3_ld_gnt_t1", 32'(ls_gnt), 32'd1);
      chk("t3_ld_w_en_t1", 32'(ram_w_en), 32'd0);
      chk("t3_no_rvalid_t1", 32'(ls_rvalid), 32'd0);
      lsq.push_back(32'hDEAD_BEEF); exp_ls_rdata = 32'hDEAD_BEEF;
      nxt();
      ls_req = 1'b0;
      @(negedge clk); chk("t3_w_en_t2", 32'(ram_w_en), 32'd0); nxt();
      @(negedge clk); chk("t3_rvalid_t3", 32'(ls_rvalid), 32'd0); nxt();
      @(negedge clk);
      chk("t3_rvalid_t4", 32'(ls_rvalid), 32'd1);
      chk("t3_rdata_t4", ls_rdata, 32'hDEAD_BEEF);
      nxt();

      // 4: continuous contention, expect LS,LS,LS,LS,IF repeating
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 11'h040;
      if_req = 1'b1; if_addr = 11'h041;
      n_gnt = 0;
      for (int c = 0; c < 100 && n_gnt < 15; c++) begin
         @(negedge clk);
         if (if_gnt || ls_gnt) begin
            chk("t4_one_gnt", 32'(if_gnt & ls_gnt), 32'd0);
            chk("t4_gnt_kind", 32'(if_gnt), 32'((n_gnt % 5) == 4));
            if (if_gnt) begin
               ifq.push_back(init_word(32'h041)); exp_if_rdata = init_word(32'h041);
            end else begin
               lsq.push_back(init_word(32'h040)); exp_ls_rdata = init_word(32'h040);
            end
            n_gnt++;
         end
         nxt();
      end
      ls_req = 1'b0; if_req = 1'b0;
      chk("t4_budget", 32'(n_gnt), 32'd15);
      idle(3);

      // 5: flush suppresses an outstanding fetch
      if_req = 1'b1; if_flush = 1'b1; if_addr = 11'h012;
      @(negedge clk); chk("t5_flush_blocks_gnt", 32'(if_gnt), 32'd0); nxt();
      if_flush = 1'b0;
      @(negedge clk); chk("t5_if_gnt_t0", 32'(if_gnt), 32'd1); nxt();
      if_req = 1'b0;
      idle(1);
      if_flush = 1'b1;
      @(negedge clk); nxt();
      if_flush = 1'b0; if_req = 1'b1; if_addr = 11'h013;
      @(negedge clk);
      chk("t5_no_rvalid_t3", 32'(if_rvalid), 32'd0);
      chk("t5_rdata_kept", if_rdata, exp_if_rdata);
      chk("t5_regnt_t3", 32'(if_gnt), 32'd1);
      ifq.push_back(init_word(32'h013)); exp_if_rdata = init_word(32'h013);
      nxt();
      if_req = 1'b0;
      idle(2);
      @(negedge clk); chk("t5_rvalid_t6", 32'(if_rvalid), 32'd1); nxt();

      // 6: reset during an LS read abandons it
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 11'h050;
      @(negedge clk); chk("t6_ls_gnt", 32'(ls_gnt), 32'd1); nxt();
      ls_req = 1'b0;
      rst_n = 1'b0;
      @(negedge clk); chk_all_zero("t6_rst"); nxt();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t6_no_rvalid", 32'(ls_rvalid), 32'd0);
         chk("t6_busy", 32'(busy), 32'd0);
         nxt();
      end
      if_req = 1'b1; if_addr = 11'h014;
      @(negedge clk);
      chk("t6_first_gnt", 32'(if_gnt), 32'd1);
      ifq.push_back(init_word(32'h014));
      nxt();
      if_req = 1'b0;
      idle(3);

      chk("end_ifq_empty", 32'(ifq.size()), 32'd0);
      chk("end_lsq_empty", 32'(lsq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
